sram_1rw_masked_ext: RTL and testbench

SRAM_1RW_MASKED_EXT -- requirements
Module: sram_1rw_masked_ext

---
 rtl/sram_1rw_masked_ext.sv | 154 +++++++++++++++
 tb/tb_sram_1rw_masked_ext.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_1rw_masked_ext.sv
// Single-port SRAM with per-lane write mask and a 1- or 2-cycle registered read path.
// Define SRAM_RESET_SWEEP_EN to zero every word after reset (init_busy high while sweeping).
module sram_1rw_masked_ext #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512,
  parameter int MASK_W = 1,
  parameter int RD_LAT = 1
) (
  input  logic              RW0_clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] RW0_addr,
  input  logic              RW0_en,
  input  logic              RW0_wmode,
  input  logic [MASK_W-1:0] RW0_wmask,
  input  logic [DATA_W-1:0] RW0_wdata,
  output logic [DATA_W-1:0] RW0_rdata,
  output logic              RW0_rvalid,
  output logic              init_busy
);
  localparam int LW = DATA_W / MASK_W;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_range;
  logic              rd_acc;
  logic              wr_acc;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [MASK_W-1:0] wr_lanes;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_word;
  logic              sweep_wr;
  logic [ADDR_W-1:0] sweep_addr;

`ifdef SRAM_RESET_SWEEP_EN
  typedef enum logic {S_IDLE, S_SWEEP} state_e;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge RW0_clk) begin
    if (reset) begin
      state_q <= S_SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_SWEEP) begin
      if (cnt_q == LAST) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + ADDR_W'(1);
      end
    end
  end

  // Busy covers the reset cycles too, so nothing slips in before the sweep starts.
  always_comb begin
    init_busy  = reset || (state_q == S_SWEEP);
    sweep_wr   = !reset && (state_q == S_SWEEP);
    sweep_addr = cnt_q;
  end
`else
  assign init_busy  = 1'b0;
  assign sweep_wr   = 1'b0;
  assign sweep_addr = '0;
`endif

  // Out-of-range reads still answer (with zero); out-of-range writes are dropped.
  always_comb begin
    in_range = ({1'b0, RW0_addr} < DEPTH_X);
    rd_acc   = RW0_en && !init_busy && !reset && !RW0_wmode;
    wr_acc   = RW0_en && !init_busy && !reset && RW0_wmode && in_range;
    rd_word  = in_range ? mem[RW0_addr] : '0;

    wr_en    = wr_acc;
    wr_addr  = RW0_addr;
    wr_lanes = RW0_wmask;
    wr_data  = RW0_wdata;
    if (sweep_wr) begin
      wr_en    = 1'b1;
      wr_addr  = sweep_addr;
      wr_lanes = '1;
      wr_data  = '0;
    end
  end

  always_ff @(posedge RW0_clk) begin
    if (wr_en) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (wr_lanes[i]) mem[wr_addr][i*LW +: LW] <= wr_data[i*LW +: LW];
      end
    end
  end

  // Stage p1: array read register; data only moves on a read so it holds otherwise.
  logic              vld_p1_q, vld_p1_d;
  logic [DATA_W-1:0] rdata_p1_q, rdata_p1_d;

  always_comb begin
    vld_p1_d   = rd_acc;
    rdata_p1_d = rd_acc ? rd_word : rdata_p1_q;
  end

  always_ff @(posedge RW0_clk) begin
    if (reset) begin
      vld_p1_q   <= 1'b0;
      rdata_p1_q <= '0;
    end else begin
      vld_p1_q   <= vld_p1_d;
      rdata_p1_q <= rdata_p1_d;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      // Stage p2: extra output register, loaded only when p1 carries fresh data.
      logic              vld_p2_q, vld_p2_d;
      logic [DATA_W-1:0] rdata_p2_q, rdata_p2_d;

      always_comb begin
        vld_p2_d   = vld_p1_q;
        rdata_p2_d = vld_p1_q ? rdata_p1_q : rdata_p2_q;
      end

      always_ff @(posedge RW0_clk) begin
        if (reset) begin
          vld_p2_q   <= 1'b0;
          rdata_p2_q <= '0;
        end else begin
          vld_p2_q   <= vld_p2_d;
          rdata_p2_q <= rdata_p2_d;
        end
      end

      assign RW0_rdata  = rdata_p2_q;
      assign RW0_rvalid = vld_p2_q;
    end else begin : g_lat1
      assign RW0_rdata  = rdata_p1_q;
      assign RW0_rvalid = vld_p1_q;
    end
  endgenerate

endmodule

// File: tb/tb_sram_1rw_masked_ext.sv
// Scoreboard bench: a default 16-bit RD_LAT=1 instance and a 32-bit, 4-lane,
// RD_LAT=2, DEPTH=20 instance sharing one clock and reset.
module tb_sram_1rw_masked_ext;
  localparam int DA = 512;
  localparam int DB = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  logic [8:0]  addr_a;
  logic        en_a, wm_a;
  logic [0:0]  mask_a;
  logic [15:0] wd_a, rd_a;
  logic        rv_a, busy_a;

  logic [4:0]  addr_b;
  logic        en_b, wm_b;
  logic [3:0]  mask_b;
  logic [31:0] wd_b, rd_b;
  logic        rv_b, busy_b;

  sram_1rw_masked_ext dut_a (
    .RW0_clk(clk), .reset(rst), .RW0_addr(addr_a), .RW0_en(en_a), .RW0_wmode(wm_a),
    .RW0_wmask(mask_a), .RW0_wdata(wd_a), .RW0_rdata(rd_a), .RW0_rvalid(rv_a),
    .init_busy(busy_a)
  );

  sram_1rw_masked_ext #(.DATA_W(32), .ADDR_W(5), .DEPTH(DB), .MASK_W(4), .RD_LAT(2)) dut_b (
    .RW0_clk(clk), .reset(rst), .RW0_addr(addr_b), .RW0_en(en_b), .RW0_wmode(wm_b),
    .RW0_wmask(mask_b), .RW0_wdata(wd_b), .RW0_rdata(rd_b), .RW0_rvalid(rv_b),
    .init_busy(busy_b)
  );

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  logic [31:0] mdl_a [DA];
  logic [31:0] mdl_b [DB];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          ncyc  = 0;
  logic        rst_s = 1'b1;
  logic [31:0] last_a = '0;
  logic [31:0] last_b = '0;
  int          wa [16];

  always @(posedge clk) begin
    ncyc  <= ncyc + 1;
    rst_s <= rst;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, ncyc);
    end
  endtask

  // Output monitor: pops the scoreboard on rvalid, otherwise checks that rdata holds.
  always @(negedge clk) begin
    exp_t e;
    if (rst_s) begin
      chk("rst_rdata_a", {16'h0, rd_a}, 32'h0);
      chk("rst_rvalid_a", {31'h0, rv_a}, 32'h0);
      chk("rst_rdata_b", rd_b, 32'h0);
      chk("rst_rvalid_b", {31'h0, rv_b}, 32'h0);
`ifdef SRAM_RESET_SWEEP_EN
      chk("rst_busy_a", {31'h0, busy_a}, 32'h1);
      chk("rst_busy_b", {31'h0, busy_b}, 32'h1);
`endif
      qa.delete();
      qb.delete();
      last_a = '0;
      last_b = '0;
    end else begin
      if (rv_a) begin
        if (qa.size() == 0) chk("rvalid_a_spurious", {31'h0, rv_a}, 32'h0);
        else begin
          e = qa.pop_front();
          chk("lat_a", ncyc, e.due);
          chk("data_a", {16'h0, rd_a}, e.data);
        end
        last_a = {16'h0, rd_a};
      end else begin
        chk("hold_a", {16'h0, rd_a}, last_a);
        if (qa.size() > 0 && qa[0].due <= ncyc) begin
          chk("rvalid_a_missing", {31'h0, rv_a}, 32'h1);
          void'(qa.pop_front());
        end
      end
      if (rv_b) begin
        if (qb.size() == 0) chk("rvalid_b_spurious", {31'h0, rv_b}, 32'h0);
        else begin
          e = qb.pop_front();
          chk("lat_b", ncyc, e.due);
          chk("data_b", rd_b, e.data);
        end
        last_b = rd_b;
      end else begin
        chk("hold_b", rd_b, last_b);
        if (qb.size() > 0 && qb[0].due <= ncyc) begin
          chk("rvalid_b_missing", {31'h0, rv_b}, 32'h1);
          void'(qb.pop_front());
        end
      end
    end
`ifndef SRAM_RESET_SWEEP_EN
    chk("busy_off_a", {31'h0, busy_a}, 32'h0);
    chk("busy_off_b", {31'h0, busy_b}, 32'h0);
`endif
  end

  task automatic model_write(input bit s, input int addr, input logic [31:0] d,
                             input logic [3:0] m);
    if (!s) begin
      if (addr < DA && m[0]) mdl_a[addr] = {16'h0, d[15:0]};
    end else if (addr < DB) begin
      for (int i = 0; i < 4; i++)
        if (m[i]) mdl_b[addr][i*8 +: 8] = d[i*8 +: 8];
    end
  endtask

  // Drives one request in the current cycle and records what it should produce.
  task automatic drive(input bit s, input bit w, input int addr, input logic [31:0] d,
                       input logic [3:0] m);
    exp_t e;
    en_a = 1'b0;
    en_b = 1'b0;
    if (!s) begin
      en_a = 1'b1; wm_a = w; addr_a = addr[8:0]; wd_a = d[15:0]; mask_a = m[0:0];
    end else begin
      en_b = 1'b1; wm_b = w; addr_b = addr[4:0]; wd_b = d; mask_b = m;
    end
    if (w) model_write(s, addr, d, m);
    else begin
      e.due  = ncyc + (s ? 2 : 1);
      e.data = s ? ((addr < DB) ? mdl_b[addr] : 32'h0) : mdl_a[addr];
      if (s) qb.push_back(e);
      else   qa.push_back(e);
    end
  endtask

  task automatic op(input bit s, input bit w, input int addr, input logic [31:0] d,
                    input logic [3:0] m);
    @(negedge clk);
    drive(s, w, addr, d, m);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      en_a = 1'b0;
      en_b = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1; en_a = 1'b0; en_b = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Counts busy cycles from the release cycle on; optionally pokes writes mid-sweep.
  task automatic sweep_count(input bit poke, output int na, output int nb);
    na = 0;
    nb = 0;
    for (int i = 0; i < 2000 && (busy_a || busy_b); i++) begin
      if (busy_a) na++;
      if (busy_b) nb++;
      wm_a = 1'b1; addr_a = 9'd7; wd_a = 16'h1234; mask_a = 1'b1;
      wm_b = 1'b1; addr_b = 5'd3; wd_b = 32'hDEADBEEF; mask_b = 4'hF;
      en_a = poke && (i == 50);
      en_b = poke && (i == 10);
      @(negedge clk);
      #1;
    end
    en_a = 1'b0;
    en_b = 1'b0;
  endtask

  function automatic int busy_exp(input int depth);
`ifdef SRAM_RESET_SWEEP_EN
    return depth;
`else
    return 0;
`endif
  endfunction

  task automatic zero_models();
`ifdef SRAM_RESET_SWEEP_EN
    foreach (mdl_a[i]) mdl_a[i] = '0;
    foreach (mdl_b[i]) mdl_b[i] = '0;
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int na, nb;
    en_a = 0; wm_a = 0; addr_a = '0; mask_a = '0; wd_a = '0;
    en_b = 0; wm_b = 0; addr_b = '0; mask_b = '0; wd_b = '0;
    foreach (mdl_a[i]) mdl_a[i] = '0;
    foreach (mdl_b[i]) mdl_b[i] = '0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    sweep_count(1'b1, na, nb);
    chk("sweep_len_a", na, busy_exp(DA));
    chk("sweep_len_b", nb, busy_exp(DB));
    zero_models();

`ifdef SRAM_RESET_SWEEP_EN
    op(0, 0, 511, 0, 0);
    op(0, 0, 7, 0, 0);
    op(1, 0, 19, 0, 0);
    op(1, 0, 3, 0, 0);
`else
    drive(0, 1, 0, 32'hBEEF, 4'h1);
    op(0, 0, 0, 0, 0);
`endif
    idle(3);

    // Lane-masked merge on the 4-lane instance.
    op(1, 1, 5, 32'hAABBCCDD, 4'hF);
    op(1, 1, 5, 32'h11223344, 4'b0101);
    op(1, 0, 5, 0, 0);
    idle(3);

    // Back-to-back reads through the two-stage read path.
    op(1, 1, 1, 32'h1, 4'hF);
    op(1, 1, 2, 32'h2, 4'hF);
    op(1, 1, 3, 32'h3, 4'hF);
    op(1, 0, 1, 0, 0);
    op(1, 0, 2, 0, 0);
    op(1, 0, 3, 0, 0);
    idle(4);

    for (int i = 0; i < DB; i++) op(1, 1, i, $urandom, 4'hF);
    for (int i = 0; i < 30; i++)
      op(1, 1, $urandom_range(0, DB-1), $urandom, 4'($urandom_range(0, 15)));
    for (int i = 0; i < DB; i++) op(1, 0, i, 0, 0);
    op(1, 1, 25, 32'hCAFEF00D, 4'hF);
    op(1, 0, 25, 0, 0);
    op(1, 0, 31, 0, 0);
    idle(3);

    for (int i = 0; i < 16; i++) begin
      wa[i] = $urandom_range(0, DA-1);
      op(0, 1, wa[i], $urandom, 4'h1);
    end
    op(0, 1, wa[0], 32'h5555, 4'h0);
    for (int i = 0; i < 16; i++) op(0, 0, wa[i], 0, 0);
    op(0, 1, 100, 32'h0000A5C3, 4'h1);
    op(0, 0, 100, 0, 0);
    op(0, 1, 100, 32'h00003C5A, 4'h1);
    idle(2);
    op(0, 0, 100, 0, 0);
    idle(3);

    // In-flight read abandoned by reset, then reset again partway through the sweep.
    op(1, 0, 2, 0, 0);
    pulse_reset();
    repeat (100) @(negedge clk);
    pulse_reset();
    #1;
    sweep_count(1'b0, na, nb);
    chk("resweep_len_a", na, busy_exp(DA));
    chk("resweep_len_b", nb, busy_exp(DB));
    zero_models();

    for (int i = 0; i < 8; i++) op(0, 0, wa[i], 0, 0);
    op(1, 0, 5, 0, 0);
    op(1, 0, 1, 0, 0);
    idle(6);

    chk("drain_a", qa.size(), 0);
    chk("drain_b", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
